// File: rtl/coax_pkg.sv
// coax_pkg: shared word width and transmit controller state encoding
package coax_pkg;
  localparam int COAX_WORD_BITS = 10;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_DRAIN,
    ST_GAP
  } tx_state_e;
endpackage

// File: rtl/coax_fifo.sv
// coax_fifo: synchronous FIFO with first-word-fall-through head, occupancy and overflow pulse
// Ports: wr_en_i/wr_data_i push; rd_en_i pops head rd_data_o; full_o, level_o occupancy;
//        overflow_o pulses the cycle after a write was dropped because the FIFO was full.
module coax_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     full_o,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic overflow_q, overflow_d;
  logic push, pop;
  assign pop = rd_en_i && (level_q != '0);
  // a pop in the same cycle frees the slot, so a write on a full FIFO is still accepted
  assign push = wr_en_i && (!full_o || pop);
  assign full_o = level_q == LW'(DEPTH);
  assign level_d = level_q + LW'(push) - LW'(pop);
  assign overflow_d = wr_en_i && !push;
  assign rd_data_o = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign overflow_o = overflow_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_q + AW'(push);
      rd_ptr_q <= rd_ptr_q + AW'(pop);
      level_q <= level_d;
      overflow_q <= overflow_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end
endmodule

// File: rtl/coax_tx_ctrl.sv
// coax_tx_ctrl: buffers host words and sequences one frame at a time through the coax transmitter
// Ports: wr_data/wr_strobe host write (full, overflow, level); go/go_error/busy frame control;
//        tx_start/tx_data/tx_valid/tx_ack/tx_active handshake with the bit-level transmitter.
module coax_tx_ctrl
  import coax_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int GAP_CLOCKS = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [COAX_WORD_BITS-1:0] wr_data,
  input  logic                      wr_strobe,
  output logic                      full,
  output logic                      overflow,
  input  logic                      go,
  output logic                      go_error,
  output logic                      busy,
  output logic [$clog2(DEPTH):0]    level,
  output logic                      tx_start,
  output logic [COAX_WORD_BITS-1:0] tx_data,
  output logic                      tx_valid,
  input  logic                      tx_ack,
  input  logic                      tx_active
);
  localparam int LW = $clog2(DEPTH) + 1;
  localparam int GW = $clog2(GAP_CLOCKS + 1);
  tx_state_e state_q, state_d;
  logic [LW-1:0] frame_len_q, frame_len_d;
  logic [GW-1:0] gap_q, gap_d;
  logic armed_q, armed_d;
  logic go_error_q, go_error_d;
  logic pop;
  logic [COAX_WORD_BITS-1:0] head;
  coax_fifo #(
    .WIDTH(COAX_WORD_BITS),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (wr_strobe),
    .wr_data_i (wr_data),
    .rd_en_i   (pop),
    .rd_data_o (head),
    .full_o    (full),
    .overflow_o(overflow),
    .level_o   (level)
  );
  always_comb begin
    state_d = state_q;
    frame_len_d = frame_len_q;
    gap_d = gap_q;
    armed_d = 1'b0;
    pop = 1'b0;
    go_error_d = go && (state_q != ST_IDLE || level == '0);
    case (state_q)
      ST_IDLE: begin
        if (go && level != '0) begin
          frame_len_d = level;
          state_d = ST_START;
        end
      end
      ST_START: state_d = ST_DATA;
      ST_DATA: begin
        if (tx_ack) begin
          pop = 1'b1;
          frame_len_d = frame_len_q - LW'(1);
          if (frame_len_q == LW'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // tx_active is ignored in the entry cycle: the transmitter may not have reacted to the last ack yet
        armed_d = 1'b1;
        if (armed_q && !tx_active) begin
          gap_d = GW'(GAP_CLOCKS);
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        gap_d = gap_q - GW'(1);
        if (gap_q == GW'(1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      frame_len_q <= '0;
      gap_q <= '0;
      armed_q <= 1'b0;
      go_error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_len_q <= frame_len_d;
      gap_q <= gap_d;
      armed_q <= armed_d;
      go_error_q <= go_error_d;
    end
  end
  assign busy = state_q != ST_IDLE;
  assign tx_start = state_q == ST_START;
  assign tx_valid = state_q == ST_DATA;
  assign tx_data = tx_valid ? head : '0;
  assign go_error = go_error_q;
endmodule

// File: tb/tb_coax_tx_ctrl.sv
// tb_coax_tx_ctrl: directed self-checking bench for coax_tx_ctrl
module tb_coax_tx_ctrl;
  localparam int DEPTH = 32;
  localparam int GAP = 64;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [9:0] wr_data = '0;
  logic wr_strobe = 1'b0;
  logic go = 1'b0;
  logic tx_ack = 1'b0;
  logic tx_active = 1'b0;
  logic full, overflow, go_error, busy, tx_start, tx_valid;
  logic [5:0] level;
  logic [9:0] tx_data;
  int checks = 0;
  int errors = 0;
  logic [9:0] rx_words [64];
  int rx_cnt, n_start, act_fall, busy_fall, go_err_cnt;
  bit timed_out;

  coax_tx_ctrl #(.DEPTH(DEPTH), .GAP_CLOCKS(GAP)) dut (
    .clk(clk), .reset(reset), .wr_data(wr_data), .wr_strobe(wr_strobe),
    .full(full), .overflow(overflow), .go(go), .go_error(go_error),
    .busy(busy), .level(level), .tx_start(tx_start), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ack(tx_ack), .tx_active(tx_active)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] d);
    wr_strobe = 1'b1;
    wr_data = d;
    tick();
    wr_strobe = 1'b0;
  endtask

  task automatic pulse_go();
    go = 1'b1;
    tick();
    go = 1'b0;
  endtask

  function automatic logic [9:0] pat(input int k);
    return 10'(k * 37 + 5);
  endfunction

  // transmitter model: acks lat cycles after tx_valid, keeps tx_active high hold cycles past the last ack;
  // optionally pulses go at cycle go_at and writes wr_n words from cycle 3; runs until busy falls
  task automatic xmit(input int lat, input int hold, input int go_at, input int wr_n, input logic [9:0] wr_base);
    int w = 0;
    int remain = 0;
    bit active = 1'b0;
    n_start = 0; rx_cnt = 0; act_fall = -1; busy_fall = -1; go_err_cnt = 0; timed_out = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      if (tx_start) begin n_start++; active = 1'b1; end
      if (go_error) go_err_cnt++;
      tx_ack = 1'b0; go = 1'b0; wr_strobe = 1'b0;
      if (!busy) begin busy_fall = c; timed_out = 1'b0; break; end
      if (tx_valid) begin
        if (w == lat) begin
          tx_ack = 1'b1;
          if (rx_cnt < 64) rx_words[rx_cnt] = tx_data;
          rx_cnt++;
          remain = hold;
          w = 0;
        end else w++;
      end else if (active && rx_cnt > 0) begin
        if (remain > 0) remain--;
        else begin active = 1'b0; act_fall = c; end
      end
      if (c == go_at) go = 1'b1;
      if (c >= 3 && c < 3 + wr_n) begin wr_strobe = 1'b1; wr_data = wr_base + 10'(c - 3); end
      tx_active = active;
      tick();
    end
    tx_ack = 1'b0; go = 1'b0; wr_strobe = 1'b0; tx_active = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || tx_valid !== 1'b0 || tx_start !== 1'b0) begin errors++; $display("FAIL reset_ctrl: busy=%b valid=%b start=%b required 0 0 0", busy, tx_valid, tx_start); end
    checks++; if (level !== 6'd0 || full !== 1'b0) begin errors++; $display("FAIL reset_fifo: level=%0d full=%b required 0 0", level, full); end
    checks++; if (overflow !== 1'b0 || go_error !== 1'b0 || tx_data !== 10'd0) begin errors++; $display("FAIL reset_misc: ovf=%b gerr=%b data=%h required 0 0 000", overflow, go_error, tx_data); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_frame();
    wr(10'h101); wr(10'h2AA); wr(10'h3FF);
    checks++; if (level !== 6'd3) begin errors++; $display("FAIL basic_level: got %0d required 3", level); end
    pulse_go();
    checks++; if (busy !== 1'b1 || tx_start !== 1'b1 || tx_valid !== 1'b0) begin errors++; $display("FAIL basic_go_timing: busy=%b start=%b valid=%b required 1 1 0", busy, tx_start, tx_valid); end
    xmit(4, 50, -1, 0, 10'h0);
    checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: busy never fell"); end
    checks++; if (n_start !== 1) begin errors++; $display("FAIL basic_starts: got %0d required 1", n_start); end
    checks++; if (rx_cnt !== 3 || rx_words[0] !== 10'h101 || rx_words[1] !== 10'h2AA || rx_words[2] !== 10'h3FF) begin errors++; $display("FAIL basic_words: cnt=%0d %h %h %h required 3 101 2aa 3ff", rx_cnt, rx_words[0], rx_words[1], rx_words[2]); end
    checks++; if (busy_fall - act_fall !== GAP + 1) begin errors++; $display("FAIL basic_gap: got %0d required %0d", busy_fall - act_fall, GAP + 1); end
    checks++; if (level !== 6'd0) begin errors++; $display("FAIL basic_level_end: got %0d required 0", level); end
  endtask

  task automatic test_go_error();
    pulse_go();
    checks++; if (go_error !== 1'b1 || busy !== 1'b0 || tx_start !== 1'b0) begin errors++; $display("FAIL goerr_empty: gerr=%b busy=%b start=%b required 1 0 0", go_error, busy, tx_start); end
    tick();
    checks++; if (go_error !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL goerr_pulse: gerr=%b busy=%b required 0 0", go_error, busy); end
    wr(10'h011); wr(10'h022);
    pulse_go();
    xmit(2, 5, 10, 0, 10'h0);
    checks++; if (go_err_cnt !== 1) begin errors++; $display("FAIL goerr_busy: got %0d pulses required 1", go_err_cnt); end
    checks++; if (timed_out || n_start !== 1 || rx_cnt !== 2 || rx_words[0] !== 10'h011 || rx_words[1] !== 10'h022) begin errors++; $display("FAIL goerr_frame: to=%b starts=%0d cnt=%0d %h %h required 0 1 2 011 022", timed_out, n_start, rx_cnt, rx_words[0], rx_words[1]); end
  endtask

  task automatic test_len_fixed();
    wr(10'h0A1); wr(10'h0A2);
    pulse_go();
    xmit(1, 3, -1, 5, 10'h150);
    checks++; if (rx_cnt !== 2 || rx_words[0] !== 10'h0A1 || rx_words[1] !== 10'h0A2) begin errors++; $display("FAIL len_first: cnt=%0d %h %h required 2 0a1 0a2", rx_cnt, rx_words[0], rx_words[1]); end
    checks++; if (level !== 6'd5) begin errors++; $display("FAIL len_level: got %0d required 5", level); end
    pulse_go();
    xmit(1, 3, -1, 0, 10'h0);
    checks++; if (timed_out || rx_cnt !== 5) begin errors++; $display("FAIL len_second_cnt: to=%b cnt=%0d required 0 5", timed_out, rx_cnt); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (rx_words[i] !== 10'h150 + 10'(i)) begin errors++; $display("FAIL len_second_word%0d: got %h required %h", i, rx_words[i], 10'h150 + 10'(i)); end
    end
  endtask

  task automatic test_overflow_wrap();
    int k = 0;
    int e = 32;
    int bad;
    for (int i = 0; i < DEPTH; i++) begin wr(pat(k)); k++; end
    checks++; if (full !== 1'b1 || level !== 6'd32) begin errors++; $display("FAIL ovf_fill: full=%b level=%0d required 1 32", full, level); end
    wr(10'h3EE);
    checks++; if (overflow !== 1'b1 || level !== 6'd32) begin errors++; $display("FAIL ovf_pulse: ovf=%b level=%0d required 1 32", overflow, level); end
    tick();
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b required 0", overflow); end
    pulse_go();
    tick();
    checks++; if (tx_valid !== 1'b1 || tx_data !== pat(0)) begin errors++; $display("FAIL ovf_head: valid=%b data=%h required 1 %h", tx_valid, tx_data, pat(0)); end
    tx_ack = 1'b1; wr_strobe = 1'b1; wr_data = pat(32);
    tick();
    tx_ack = 1'b0; wr_strobe = 1'b0;
    checks++; if (overflow !== 1'b0 || level !== 6'd32 || tx_data !== pat(1)) begin errors++; $display("FAIL ovf_wr_pop: ovf=%b level=%0d data=%h required 0 32 %h", overflow, level, tx_data, pat(1)); end
    k = 33;
    xmit(0, 1, -1, 0, 10'h0);
    bad = 0;
    for (int i = 0; i < 31; i++) if (rx_words[i] !== pat(i + 1)) bad++;
    checks++; if (timed_out || rx_cnt !== 31 || bad !== 0) begin errors++; $display("FAIL ovf_rest: to=%b cnt=%0d bad=%0d required 0 31 0", timed_out, rx_cnt, bad); end
    checks++; if (level !== 6'd1) begin errors++; $display("FAIL ovf_left: got %0d required 1", level); end
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < ((f == 0) ? 31 : 32); i++) begin wr(pat(k)); k++; end
      pulse_go();
      xmit(0, 1, -1, 0, 10'h0);
      bad = 0;
      for (int i = 0; i < 32; i++) if (rx_words[i] !== pat(e + i)) bad++;
      checks++; if (timed_out || rx_cnt !== 32 || bad !== 0) begin errors++; $display("FAIL wrap_frame%0d: to=%b cnt=%0d bad=%0d required 0 32 0", f, timed_out, rx_cnt, bad); end
      e += 32;
    end
  endtask

  task automatic test_reset_mid();
    wr(10'h201); wr(10'h202); wr(10'h203); wr(10'h204);
    pulse_go();
    tick();
    checks++; if (tx_valid !== 1'b1) begin errors++; $display("FAIL rst_in_data: valid=%b required 1", tx_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (tx_valid !== 1'b0 || busy !== 1'b0 || level !== 6'd0) begin errors++; $display("FAIL rst_mid: valid=%b busy=%b level=%0d required 0 0 0", tx_valid, busy, level); end
    wr(10'h155);
    pulse_go();
    xmit(1, 2, -1, 0, 10'h0);
    checks++; if (timed_out || n_start !== 1 || rx_cnt !== 1 || rx_words[0] !== 10'h155) begin errors++; $display("FAIL rst_after: to=%b starts=%0d cnt=%0d w0=%h required 0 1 1 155", timed_out, n_start, rx_cnt, rx_words[0]); end
  endtask

  task automatic test_back_to_back();
    wr(10'h0C1); wr(10'h0C2); wr(10'h0C3); wr(10'h0C4);
    pulse_go();
    xmit(0, 1, -1, 0, 10'h0);
    checks++; if (timed_out || rx_cnt !== 4) begin errors++; $display("FAIL b2b_cnt: to=%b cnt=%0d required 0 4", timed_out, rx_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (rx_words[i] !== 10'h0C1 + 10'(i)) begin errors++; $display("FAIL b2b_word%0d: got %h required %h", i, rx_words[i], 10'h0C1 + 10'(i)); end
    end
    checks++; if (busy_fall - act_fall !== GAP + 1) begin errors++; $display("FAIL b2b_gap: got %0d required %0d", busy_fall - act_fall, GAP + 1); end
  endtask

  initial begin
    tick();
    test_reset();
    test_basic_frame();
    test_go_error();
    test_len_fixed();
    test_overflow_wrap();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
